// File: rtl/icu_sequencer.sv
// Instruction sequencer for a 1-bit ICU-style controller.
// It runs a fetch/execute FSM with one-cycle strobes and a 4-entry return stack.
module icu_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        run,
    input  logic [15:0] instr_data,
    input  logic [15:0] pc_addr,
    input  logic        rr,
    output logic        pc_step,
    output logic        pc_addr_w,
    output logic [15:0] pc_addr_in,
    output logic        exec_en,
    output logic        write_en,
    output logic        flag_o,
    output logic        flag_f,
    output logic        flag_j,
    output logic        flag_r,
    output logic [2:0]  stack_depth,
    output logic        stack_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        SKIP  = 2'd3
    } state_t;

    localparam logic [3:0] OP_NOPO = 4'h0;
    localparam logic [3:0] OP_STO  = 4'h8;
    localparam logic [3:0] OP_STOC = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_RTN  = 4'hD;
    localparam logic [3:0] OP_SKZ  = 4'hE;
    localparam logic [3:0] OP_NOPF = 4'hF;

    state_t      state_r;
    state_t      state_s;
    logic [15:0] ir_r;
    logic [15:0] stack_r [4];
    logic [2:0]  depth_r;
    logic        err_r;
    logic [3:0]  opcode_s;
    logic [1:0]  top_idx_s;
    logic        push_s;
    logic        pop_s;
    logic        set_err_s;

    assign opcode_s    = ir_r[15:12];
    // Depth 4 wraps to index 0 in two bits, so subtracting one still lands on entry 3.
    assign top_idx_s   = depth_r[1:0] - 2'd1;
    assign stack_depth = depth_r;
    assign stack_err   = err_r;

    // Next-state and strobe decode from state and the latched instruction.
    always_comb begin
        state_s    = state_r;
        pc_step    = 1'b0;
        pc_addr_w  = 1'b0;
        pc_addr_in = 16'd0;
        exec_en    = 1'b0;
        write_en   = 1'b0;
        flag_o     = 1'b0;
        flag_f     = 1'b0;
        flag_j     = 1'b0;
        flag_r     = 1'b0;
        push_s     = 1'b0;
        pop_s      = 1'b0;
        set_err_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (run) begin
                    state_s = FETCH;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                state_s = EXEC;
            end
            EXEC: begin
                if (run) begin
                    state_s = FETCH;
                end else begin
                    state_s = IDLE;
                end
                case (opcode_s)
                    OP_NOPO: begin
                        flag_o  = 1'b1;
                        pc_step = 1'b1;
                    end
                    OP_JMP: begin
                        flag_j     = 1'b1;
                        pc_addr_w  = 1'b1;
                        pc_addr_in = {4'h0, ir_r[11:0]};
                        if (depth_r < 3'd4) begin
                            push_s = 1'b1;
                        end else begin
                            set_err_s = 1'b1;
                        end
                    end
                    OP_RTN: begin
                        flag_r  = 1'b1;
                        state_s = SKIP;
                        if (depth_r != 3'd0) begin
                            pc_addr_w  = 1'b1;
                            pc_addr_in = stack_r[top_idx_s];
                            pop_s      = 1'b1;
                        end else begin
                            pc_step   = 1'b1;
                            set_err_s = 1'b1;
                        end
                    end
                    OP_SKZ: begin
                        pc_step = 1'b1;
                        if (!rr) begin
                            state_s = SKIP;
                        end else begin
                            state_s = run ? FETCH : IDLE;
                        end
                    end
                    default: begin
                        exec_en = 1'b1;
                        pc_step = 1'b1;
                        if (opcode_s == OP_STO || opcode_s == OP_STOC) begin
                            write_en = 1'b1;
                        end else begin
                            write_en = 1'b0;
                        end
                        if (opcode_s == OP_NOPF) begin
                            flag_f = 1'b1;
                        end else begin
                            flag_f = 1'b0;
                        end
                    end
                endcase
            end
            SKIP: begin
                pc_step = 1'b1;
                if (run) begin
                    state_s = FETCH;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Instruction register, loaded only while fetching.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_r <= 16'd0;
        end else if (state_r == FETCH) begin
            ir_r <= instr_data;
        end else begin
            ir_r <= ir_r;
        end
    end

    // Return stack storage; a JMP saves the address after itself.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                stack_r[i] <= 16'd0;
            end
        end else if (push_s) begin
            stack_r[depth_r[1:0]] <= pc_addr + 16'd1;
        end else begin
            stack_r <= stack_r;
        end
    end

    // Stack depth counter and sticky error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            depth_r <= 3'd0;
            err_r   <= 1'b0;
        end else begin
            if (push_s) begin
                depth_r <= depth_r + 3'd1;
            end else if (pop_s) begin
                depth_r <= depth_r - 3'd1;
            end else begin
                depth_r <= depth_r;
            end
            if (set_err_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

endmodule

// File: tb/tb_icu_sequencer.sv
// Directed bench for icu_sequencer: a reference model pushes the expected per-cycle
// outputs of each instruction to a queue, which is popped and compared every cycle.
module tb_icu_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        run;
    logic [15:0] instr_data;
    logic [15:0] pc_addr;
    logic        rr;
    logic        pc_step;
    logic        pc_addr_w;
    logic [15:0] pc_addr_in;
    logic        exec_en;
    logic        write_en;
    logic        flag_o;
    logic        flag_f;
    logic        flag_j;
    logic        flag_r;
    logic [2:0]  stack_depth;
    logic        stack_err;

    typedef struct packed {
        logic        step;
        logic        ld;
        logic [15:0] addr;
        logic        ex;
        logic        wr;
        logic        fo;
        logic        ff;
        logic        fj;
        logic        fr;
        logic [2:0]  depth;
        logic        err;
    } obs_t;

    obs_t        exp_q [$];
    logic [15:0] m_stack [$];
    logic        m_err = 1'b0;
    int          checks = 0;
    int          errors = 0;

    icu_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .run         (run),
        .instr_data  (instr_data),
        .pc_addr     (pc_addr),
        .rr          (rr),
        .pc_step     (pc_step),
        .pc_addr_w   (pc_addr_w),
        .pc_addr_in  (pc_addr_in),
        .exec_en     (exec_en),
        .write_en    (write_en),
        .flag_o      (flag_o),
        .flag_f      (flag_f),
        .flag_j      (flag_j),
        .flag_r      (flag_r),
        .stack_depth (stack_depth),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o.step  = pc_step;
        o.ld    = pc_addr_w;
        o.addr  = pc_addr_in;
        o.ex    = exec_en;
        o.wr    = write_en;
        o.fo    = flag_o;
        o.ff    = flag_f;
        o.fj    = flag_j;
        o.fr    = flag_r;
        o.depth = stack_depth;
        o.err   = stack_err;
        return o;
    endfunction

    // Quiet cycle: no strobes, only the model's stack status.
    function automatic obs_t base();
        obs_t e;
        e       = '0;
        e.depth = 3'(m_stack.size());
        e.err   = m_err;
        return e;
    endfunction

    task automatic check_val(input string tag, input obs_t o, input obs_t e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Pop the next expected cycle and compare it with what the DUT shows now.
    task automatic cmp(input string tag);
        obs_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s observed=empty-queue expected=entry", tag);
        end else begin
            e = exp_q.pop_front();
            check_val(tag, sample(), e);
        end
    endtask

    // Called one cycle before the FETCH; drives one instruction and checks every cycle of it.
    task automatic issue(input logic [15:0] instr, input logic [15:0] pc, input logic rr_v,
                         input logic drop_run, input string tag);
        obs_t e;
        logic skip;
        logic [3:0] op;
        op = instr[15:12];
        skip = 1'b0;
        exp_q.push_back(base());
        e = base();
        case (op)
            4'h0: begin
                e.fo = 1'b1;
                e.step = 1'b1;
            end
            4'hC: begin
                e.fj = 1'b1;
                e.ld = 1'b1;
                e.addr = {4'h0, instr[11:0]};
                if (m_stack.size() < 4) m_stack.push_back(pc + 16'd1);
                else m_err = 1'b1;
            end
            4'hD: begin
                e.fr = 1'b1;
                skip = 1'b1;
                if (m_stack.size() > 0) begin
                    e.ld = 1'b1;
                    e.addr = m_stack.pop_back();
                end else begin
                    e.step = 1'b1;
                    m_err = 1'b1;
                end
            end
            4'hE: begin
                e.step = 1'b1;
                skip = !rr_v;
            end
            default: begin
                e.ex = 1'b1;
                e.step = 1'b1;
                e.wr = (op == 4'h8) || (op == 4'h9);
                e.ff = (op == 4'hF);
            end
        endcase
        exp_q.push_back(e);
        if (skip) begin
            e = base();
            e.step = 1'b1;
            exp_q.push_back(e);
        end
        if (drop_run) exp_q.push_back(base());
        @(negedge clk);
        instr_data = instr;
        pc_addr = pc;
        rr = rr_v;
        cmp({tag, "_fetch"});
        @(negedge clk);
        cmp({tag, "_exec"});
        if (drop_run) run = 1'b0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            cmp({tag, "_tail"});
        end
    endtask

    initial begin
        obs_t e;
        reset_n = 1'b0;
        run = 1'b0;
        rr = 1'b0;
        instr_data = 16'h0000;
        pc_addr = 16'h0000;
        repeat (2) @(negedge clk);
        check_val("reset_state", sample(), base());
        reset_n = 1'b1;
        @(negedge clk);
        check_val("idle_no_run", sample(), base());
        run = 1'b1;

        issue(16'h1000, 16'h0000, 1'b0, 1'b0, "ld_a");
        issue(16'h1000, 16'h0001, 1'b0, 1'b0, "ld_b");
        issue(16'h8005, 16'h0002, 1'b0, 1'b0, "sto");
        issue(16'h9001, 16'h0003, 1'b0, 1'b0, "stoc");
        issue(16'h0000, 16'h0004, 1'b0, 1'b0, "nopo");
        issue(16'hF000, 16'h0005, 1'b0, 1'b0, "nopf");
        issue(16'h5555, 16'h0006, 1'b1, 1'b0, "op5");
        issue(16'hC123, 16'h0010, 1'b0, 1'b0, "jmp");
        issue(16'hD000, 16'h0123, 1'b0, 1'b0, "rtn");
        issue(16'hE000, 16'h0012, 1'b0, 1'b0, "skz_taken");
        issue(16'hE000, 16'h0014, 1'b1, 1'b0, "skz_not");
        issue(16'hD000, 16'h0015, 1'b0, 1'b0, "rtn_empty");

        @(negedge clk);
        instr_data = 16'h3ABC;
        check_val("mid_fetch", sample(), base());
        @(negedge clk);
        e = base();
        e.ex = 1'b1;
        e.step = 1'b1;
        check_val("mid_exec", sample(), e);
        #2 reset_n = 1'b0;
        #1 check_val("async_reset", sample(), obs_t'(0));
        m_stack.delete();
        m_err = 1'b0;
        @(negedge clk);
        check_val("held_reset", sample(), base());
        reset_n = 1'b1;

        issue(16'hC100, 16'hFFFF, 1'b0, 1'b0, "jmp1");
        issue(16'hC200, 16'h0200, 1'b0, 1'b0, "jmp2");
        issue(16'hC300, 16'h0300, 1'b0, 1'b0, "jmp3");
        issue(16'hC400, 16'h0400, 1'b0, 1'b0, "jmp4");
        issue(16'hC500, 16'h0500, 1'b0, 1'b0, "jmp5");
        #6;
        e = '0;
        e.depth = 3'd4;
        e.err = 1'b1;
        check_val("overflow_status", '{step: 1'b0, ld: 1'b0, addr: 16'h0000, ex: 1'b0, wr: 1'b0,
                  fo: 1'b0, ff: 1'b0, fj: 1'b0, fr: 1'b0, depth: stack_depth, err: stack_err}, e);
        issue(16'hD000, 16'h0501, 1'b0, 1'b0, "rtn4");
        issue(16'hD000, 16'h0402, 1'b0, 1'b0, "rtn3");
        issue(16'hD000, 16'h0302, 1'b0, 1'b0, "rtn2");
        issue(16'hD000, 16'h0202, 1'b0, 1'b0, "rtn1");

        issue(16'hE000, 16'h0020, 1'b0, 1'b1, "skz_drop");
        @(negedge clk);
        check_val("idle_stays", sample(), base());
        run = 1'b1;
        issue(16'h2000, 16'h0022, 1'b0, 1'b0, "restart");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/icu_sequencer.md
ICU_SEQUENCER -- requirements
Module: icu_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
REQ-002 clk  input  1  rising-edge clock shared with the program counter.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 run  input  1  1 = sequencing enabled.
REQ-005 instr_data  input  16  program memory word at the current PC: [15:12] opcode, [11:0] operand.
REQ-006 pc_addr  input  16  current program counter value.
REQ-007 rr  input  1  ALU result register, used by SKZ.
REQ-008 pc_step  output  1  PC increment enable; the PC acts on the next clk edge.
REQ-009 pc_addr_w  output  1  PC load enable; the PC acts on the next clk edge.
REQ-010 pc_addr_in  output  16  PC load value.
REQ-011 exec_en  output  1  ALU execute strobe for the latched instruction.
REQ-012 write_en  output  1  memory/output write strobe for STO and STOC.
REQ-013 flag_o, flag_f, flag_j, flag_r  output  1 each  single-cycle strobes for NOPO, NOPF, JMP and RTN respectively.
REQ-014 stack_depth  output  3  number of valid return-stack entries, 0..4.
REQ-015 stack_err  output  1  sticky stack overflow/underflow indicator.

Function
REQ-016 The state machine SHALL have the states IDLE, FETCH, EXEC and SKIP.
REQ-017 IDLE: all strobes SHALL be 0; run=1 SHALL transition to FETCH, otherwise the block SHALL remain in IDLE.
REQ-018 FETCH: instr_data SHALL be latched into the instruction register (ir); no strobes SHALL assert; next state SHALL be EXEC.
REQ-019 Strobes SHALL be combinational decodes of state and ir, asserted for exactly one cycle, in EXEC or SKIP only.
REQ-020 Opcodes 0x1-0xB and 0xF in EXEC: exec_en=1 and pc_step=1; 0x8 (STO) and 0x9 (STOC) additionally assert write_en=1.
REQ-021 NOPO (0x0) in EXEC: flag_o=1, pc_step=1, exec_en=0.
REQ-022 NOPF (0xF) in EXEC: flag_f=1 in addition to REQ-020.
REQ-023 JMP (0xC) in EXEC: flag_j=1, pc_addr_w=1, and pc_addr_in={4'b0, ir[11:0]}.
REQ-024 JMP push: pc_addr+1 (modulo 2^16) SHALL be pushed if stack_depth<4; otherwise no push occurs, stack_err is set to 1, and the jump still occurs.
REQ-025 RTN (0xD) in EXEC with stack_depth>0: flag_r=1, pc_addr_w=1, pc_addr_in=top of stack, the entry is popped, and next state is SKIP.
REQ-026 RTN with stack_depth=0: flag_r=1, pc_step=1, stack_err is set to 1, and next state is SKIP.
REQ-027 SKZ (0xE) in EXEC: pc_step=1; next state SHALL be SKIP if rr=0, otherwise FETCH.
REQ-028 SKIP: pc_step=1; exec_en, write_en and all flags SHALL be 0.
REQ-029 After EXEC (except for transitions to SKIP) or after SKIP: next state SHALL be FETCH if run=1, else IDLE.
REQ-030 run=0 SHALL NOT abort an instruction in progress; the instruction completes, including any SKIP cycle.
REQ-031 pc_step and pc_addr_w SHALL never be asserted in the same cycle.
REQ-032 Every instruction SHALL take 2 cycles; SKZ-taken and RTN SHALL take 3 cycles.
REQ-033 pc_addr_in SHALL be 0 whenever pc_addr_w=0.
REQ-034 stack_err SHALL remain set until reset.

Reset
REQ-035 While reset_n=0: state=IDLE, ir=0, stack_depth=0, all stack entries=0, stack_err=0, and every output=0.
REQ-036 Reset asserted mid-instruction SHALL take effect immediately, with no strobe issued afterwards.
REQ-037 After reset_n is released, the first FETCH SHALL occur one cycle after run is sampled as 1.

Verification
REQ-038 Scenario: reset, run=1, instr_data=0x1000 (LD) -> FETCH, then EXEC with exec_en=1 and pc_step=1; 2-cycle period repeats.
REQ-039 Scenario: at pc_addr=0x0010, JMP 0xC123 -> flag_j=1, pc_addr_w=1, pc_addr_in=0x0123, stack_depth=1; a following RTN -> pc_addr_in=0x0011, then a SKIP cycle with pc_step=1 and stack_depth=0.
REQ-040 Scenario: SKZ with rr=0 -> EXEC pc_step then SKIP pc_step (no exec_en); with rr=1 -> direct return to FETCH.
REQ-041 Scenario: five JMPs without RTN -> stack_depth saturates at 4 and stack_err=1 on the fifth; RTN with empty stack -> stack_err=1, with pc_step in both EXEC and SKIP.
REQ-042 Scenario: STO 0x8005 -> write_en=1 and exec_en=1 for one cycle; NOPO 0x0000 -> flag_o=1 with exec_en=0.
REQ-043 Scenario: run dropped during a SKZ-taken EXEC -> SKIP completes, then IDLE; reset_n pulled low in EXEC -> all outputs 0 immediately.
